// File: rtl/systolic_job_if.sv
// ---------------------------------------------------------------------------
// systolic_job_if
// Bundles the command handshake, the two operand-buffer read ports and the
// array-edge outputs of the systolic job controller.
//   start, k_len          : job request and inner dimension (host -> ctrl)
//   busy, done, arr_clear : job status and PE accumulator clear (ctrl -> host/array)
//   d_rd_*, w_rd_*        : read strobe/address out, row/column data back in
//   data_arr, wt_arr      : skewed top-edge / left-edge operands (ctrl -> array)
// Modports: master = host/buffer/array side, slave = the controller.
// ---------------------------------------------------------------------------
interface systolic_job_if #(
  parameter int N  = 9,
  parameter int KW = 8
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            arr_clear;
  logic            d_rd_en;
  logic [KW-1:0]   d_rd_addr;
  logic [N*32-1:0] d_rd_data;
  logic            w_rd_en;
  logic [KW-1:0]   w_rd_addr;
  logic [N*32-1:0] w_rd_data;
  logic [N*32-1:0] data_arr;
  logic [N*32-1:0] wt_arr;

  modport master (
    output start, k_len, d_rd_data, w_rd_data,
    input  busy, done, arr_clear, d_rd_en, d_rd_addr, w_rd_en, w_rd_addr,
           data_arr, wt_arr
  );

  modport slave (
    input  start, k_len, d_rd_data, w_rd_data,
    output busy, done, arr_clear, d_rd_en, d_rd_addr, w_rd_en, w_rd_addr,
           data_arr, wt_arr
  );
endinterface

// File: rtl/systolic_job_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_job_ctrl
// Sequences one C = W x D job on an N x N systolic array: clears the PE
// accumulators, streams k_len rows of D and columns of W out of two buffers,
// skews lane i by i cycles so that operand slot k meets at every PE, waits for
// the array to drain and pulses done.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : systolic_job_if slave modport (command, buffer reads, array edges)
// All outputs are registered.
// ---------------------------------------------------------------------------
module systolic_job_ctrl #(
  parameter int N      = 9,
  parameter int KW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  systolic_job_if.slave  bus
);
  localparam int DRAIN_CYC = 2*(N-1) + PE_LAT + 1;
  localparam int CW        = KW + 1;
  localparam int DW        = N*32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clr_q, clr_d;
  logic            rd_en_q, rd_en_d;
  logic            vld_q, vld_d;
  logic [KW-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]   data_arr_q, data_arr_d;
  logic [DW-1:0]   wt_arr_q, wt_arr_d;
  logic [DW-1:0]   d_tap, w_tap;
  logic [CW-1:0]   k_ext, feed_last, drain_last;

  // Terminal counts for FEED and DRAIN.
  always_comb begin
    k_ext     = {1'b0, k_len_q};
    feed_last = k_ext + CW'(N-1);
    // A zero-length job skips FEED; DRAIN absorbs those N cycles so that the
    // start-to-done latency is the same formula for every k_len.
    if (k_len_q == {KW{1'b0}}) begin
      drain_last = CW'(N + DRAIN_CYC - 1);
    end else begin
      drain_last = CW'(DRAIN_CYC - 1);
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_len_d   = k_len_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clr_d     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    vld_d     = rd_en_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          k_len_d = bus.k_len;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = {CW{1'b0}};
        if (k_len_q == {KW{1'b0}}) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (cnt_q == feed_last) begin
          state_d = S_DRAIN;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == drain_last) begin
          state_d = S_DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state.
    if ((state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);

    // FEED cycle f reads index f for f < k_len; afterwards the address holds.
    if ((state_d == S_FEED) && (cnt_d < k_ext)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = cnt_d[KW-1:0];
    end else begin
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
    end

    data_arr_d = d_tap;
    wt_arr_d   = w_tap;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      k_len_q    <= {KW{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clr_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      vld_q      <= 1'b0;
      rd_addr_q  <= {KW{1'b0}};
      data_arr_q <= {DW{1'b0}};
      wt_arr_q   <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_len_q    <= k_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clr_q      <= clr_d;
      rd_en_q    <= rd_en_d;
      vld_q      <= vld_d;
      rd_addr_q  <= rd_addr_d;
      data_arr_q <= data_arr_d;
      wt_arr_q   <= wt_arr_d;
    end
  end

  // Per-lane skew: lane i is delayed by i registers; zeros enter whenever the
  // buffer data is not the response to a read strobe.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [31:0] d_in, w_in;
    assign d_in = vld_q ? bus.d_rd_data[(N-i)*32-1 -: 32] : 32'h0;
    assign w_in = vld_q ? bus.w_rd_data[(N-i)*32-1 -: 32] : 32'h0;

    if (i == 0) begin : g_direct
      assign d_tap[(N-i)*32-1 -: 32] = d_in;
      assign w_tap[(N-i)*32-1 -: 32] = w_in;
    end else begin : g_chain
      logic [31:0] d_sh_q [0:i-1];
      logic [31:0] d_sh_d [0:i-1];
      logic [31:0] w_sh_q [0:i-1];
      logic [31:0] w_sh_d [0:i-1];

      // Shift one stage per cycle.
      always_comb begin
        d_sh_d[0] = d_in;
        w_sh_d[0] = w_in;
        for (int s = 1; s < i; s++) begin
          d_sh_d[s] = d_sh_q[s-1];
          w_sh_d[s] = w_sh_q[s-1];
        end
      end

      // Skew stage registers, flushed by reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          d_sh_q <= '{default: 32'h0};
          w_sh_q <= '{default: 32'h0};
        end else begin
          d_sh_q <= d_sh_d;
          w_sh_q <= w_sh_d;
        end
      end

      assign d_tap[(N-i)*32-1 -: 32] = d_sh_q[i-1];
      assign w_tap[(N-i)*32-1 -: 32] = w_sh_q[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.arr_clear = clr_q;
  assign bus.d_rd_en   = rd_en_q;
  assign bus.w_rd_en   = rd_en_q;
  assign bus.d_rd_addr = rd_addr_q;
  assign bus.w_rd_addr = rd_addr_q;
  assign bus.data_arr  = data_arr_q;
  assign bus.wt_arr    = wt_arr_q;

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_job_ctrl
// Randomized bench for systolic_job_ctrl. Buffers hold D and W matrices; every
// job's edge streams are checked slot-by-slot against where operand k of each
// lane must appear, and C is rebuilt from the captured streams with a
// dataflow model of the array and compared with the matrix product W x D.
// ---------------------------------------------------------------------------
module tb_systolic_job_ctrl;
  localparam int N     = 9;
  localparam int KW    = 8;
  localparam int DRAIN = 2*(N-1) + 1 + 1;
  localparam int KMAX  = 24;
  localparam int TMAX  = KMAX + N + DRAIN + 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_job_if #(.N(N), .KW(KW)) bus ();

  systolic_job_ctrl #(.N(N), .KW(KW), .PE_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] dm [0:KMAX-1][0:N-1];   // D[k][c]
  logic [31:0] wm [0:N-1][0:KMAX-1];   // W[r][k]
  logic [31:0] dh [0:TMAX][0:N-1];     // captured data_arr lanes per cycle
  logic [31:0] wh [0:TMAX][0:N-1];     // captured wt_arr lanes per cycle

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*32-1:0] pack_d(input int a);
    logic [N*32-1:0] v;
    v = '0;
    if (a < KMAX) for (int i = 0; i < N; i++) v[(N-i)*32-1 -: 32] = dm[a][i];
    return v;
  endfunction

  function automatic logic [N*32-1:0] pack_w(input int a);
    logic [N*32-1:0] v;
    v = '0;
    if (a < KMAX) for (int i = 0; i < N; i++) v[(N-i)*32-1 -: 32] = wm[i][a];
    return v;
  endfunction

  // Buffer model: data returned one cycle after the strobe, held otherwise.
  always @(posedge clk) begin
    if (bus.d_rd_en) bus.d_rd_data <= pack_d(int'(bus.d_rd_addr));
    if (bus.w_rd_en) bus.w_rd_data <= pack_w(int'(bus.w_rd_addr));
  end

  // mode 0 random, 1 W=I & D=16k+c, 2 all ones, 3 W[r][0]=r+1 & D=2
  task automatic fill(input int mode);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < N; i++) begin
        case (mode)
          1: begin dm[k][i] = 32'(16*k + i); wm[i][k] = (i == k) ? 32'd1 : 32'd0; end
          2: begin dm[k][i] = 32'd1;         wm[i][k] = 32'd1; end
          3: begin dm[k][i] = 32'd2;         wm[i][k] = 32'(i + 1); end
          default: begin
            dm[k][i] = $urandom_range(1, 255);
            wm[i][k] = $urandom_range(1, 255);
          end
        endcase
      end
    end
  endtask

  task automatic run_job(input int k, input bit hold, input bit poke, input int rst_at);
    bit found;
    bit aborted;
    int done_exp, tend, done_t, n_done, n_clr, n_rd, skew_bad, busy_bad, c_bad, seen, kk;
    logic [31:0] e, acc, cexp;

    for (int t = 0; t <= TMAX; t++) for (int i = 0; i < N; i++) begin
      dh[t][i] = 32'h0; wh[t][i] = 32'h0;
    end
    done_exp = 1 + k + N + DRAIN;
    tend     = hold ? done_exp : done_exp + 3;
    done_t = -1; n_done = 0; n_clr = 0; n_rd = 0;
    skew_bad = 0; busy_bad = 0; aborted = 0;

    bus.k_len = KW'(k);
    bus.start = 1'b1;
    found = 0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(posedge clk); #1;
      if (bus.arr_clear) found = 1;
    end
    check_eq("accept", found, 1);
    if (!found) begin
      bus.start = 1'b0;
      return;
    end
    // Changing k_len after acceptance must not affect the running job.
    bus.k_len = KW'($urandom_range(0, 255));

    for (int t = 0; t <= tend; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < N; i++) begin
        dh[t][i] = bus.data_arr[(N-i)*32-1 -: 32];
        wh[t][i] = bus.wt_arr[(N-i)*32-1 -: 32];
        kk = t - 3 - i;   // operand slot carried by lane i in this cycle
        e = (kk >= 0 && kk < k) ? dm[kk][i] : 32'h0;
        if (dh[t][i] !== e) skew_bad++;
        e = (kk >= 0 && kk < k) ? wm[i][kk] : 32'h0;
        if (wh[t][i] !== e) skew_bad++;
      end
      if (bus.arr_clear) n_clr++;
      if (bus.done) begin n_done++; done_t = t; end
      if (bus.busy !== (t < done_exp)) busy_bad++;
      if (bus.d_rd_en) begin
        n_rd++;
        check_eq("d_rd_addr", bus.d_rd_addr, t - 1);
        check_eq("w_rd_addr", bus.w_rd_addr, t - 1);
        check_eq("w_rd_en", bus.w_rd_en, 1);
      end
      if (t == rst_at) begin
        reset = 1'b0;
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_data_arr", |bus.data_arr, 0);
        check_eq("rst_wt_arr", |bus.wt_arr, 0);
        check_eq("rst_rd_en", bus.d_rd_en, 0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (50) begin
          @(posedge clk); #1;
          if (bus.done || bus.busy) seen++;
        end
        check_eq("rst_no_done", seen, 0);
        aborted = 1;
        break;
      end
      if (!hold) bus.start = poke && (t == 5 || t == 30);
    end
    if (aborted) return;

    check_eq("done_cycle", done_t, done_exp);
    check_eq("done_count", n_done, 1);
    check_eq("clear_count", n_clr, 1);
    check_eq("read_count", n_rd, k);
    check_eq("skew_slots", skew_bad, 0);
    check_eq("busy_window", busy_bad, 0);

    // PE(r,c) meets data lane c leaving the edge at s with weight lane r
    // leaving at s + r - c.
    c_bad = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = 32'h0;
        for (int s = 0; s <= TMAX; s++) begin
          kk = s + r - c;
          if (kk >= 0 && kk <= TMAX) acc = acc + dh[s][c] * wh[kk][r];
        end
        cexp = 32'h0;
        for (int j = 0; j < k; j++) cexp = cexp + wm[r][j] * dm[j][c];
        if (acc !== cexp) c_bad++;
      end
    end
    check_eq("result_C", c_bad, 0);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_clear", bus.arr_clear, 0);
    check_eq("reset_rd_en", bus.d_rd_en | bus.w_rd_en, 0);
    check_eq("reset_addr", {bus.d_rd_addr, bus.w_rd_addr}, 0);
    check_eq("reset_arrays", |{bus.data_arr, bus.wt_arr}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    fill(1); run_job(9, 0, 0, -1);   // identity weights: C = D, done at 37
    fill(3); run_job(1, 0, 0, -1);   // single slot: C[r][c] = 2*(r+1)
    fill(0); run_job(0, 0, 0, -1);   // empty job: no reads, done at 28
    fill(0); run_job(9, 0, 1, -1);   // extra start pulses ignored
    fill(0); run_job(9, 0, 0, 5);    // reset at FEED cycle 4
    fill(0); run_job(9, 0, 0, -1);   // clean job after the reset
    fill(2); run_job(9, 1, 0, -1);   // back-to-back, start held
    fill(1); run_job(9, 0, 0, -1);
    for (int j = 0; j < 6; j++) begin
      fill(0);
      run_job($urandom_range(0, KMAX-1), 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
